hamming74_dec: RTL and testbench

HAMMING74_DEC -- requirements
Module: hamming74_dec

---
 rtl/hamming74_dec_if.sv | 37 +++
 rtl/hamming74_dec.sv | 161 ++++++++++++++++
 tb/tb_hamming74_dec.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hamming74_dec_if.sv
// Stream bus for the Hamming(7,4)+parity decoder: code input side, decoded output side and
// per-word error status.
interface hamming74_dec_if;
   logic [8:0] i_code;
   logic       i_valid;
   logic       o_ready;
   logic [8:0] o_data;
   logic       o_valid;
   logic       i_ready;
   logic       o_sec;
   logic       o_ded;
   logic [3:0] o_err_pos;

   modport slave (
      input  i_code,
      input  i_valid,
      input  i_ready,
      output o_ready,
      output o_data,
      output o_valid,
      output o_sec,
      output o_ded,
      output o_err_pos
   );

   modport master (
      output i_code,
      output i_valid,
      output i_ready,
      input  o_ready,
      input  o_data,
      input  o_valid,
      input  o_sec,
      input  o_ded,
      input  o_err_pos
   );
endinterface

// File: rtl/hamming74_dec.sv
// Two-stage SEC-DED decoder for an extended Hamming(7,4) word with an unprotected sideband flag,
// ready/valid flow control and saturating corrected/double-error statistics.
module hamming74_dec #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   hamming74_dec_if.slave   io_bus,
   input  logic             i_clr,
   output logic [CNT_W-1:0] o_sec_cnt,
   output logic [CNT_W-1:0] o_ded_cnt
);

   localparam logic [CNT_W-1:0] CntMax = '1;

   // Stage 1 state
   logic       r_s1_valid;
   logic [8:0] r_s1_code;
   logic [2:0] r_s1_syn;
   logic       r_s1_par;

   // Stage 2 state
   logic       r_s2_valid;
   logic [8:0] r_s2_data;
   logic       r_s2_sec;
   logic       r_s2_ded;
   logic [3:0] r_s2_pos;

   logic             r_rdy_en;
   logic [CNT_W-1:0] r_sec_cnt;
   logic [CNT_W-1:0] r_ded_cnt;

   logic       w_s2_adv;
   logic       w_s1_adv;
   logic       w_ready;
   logic       w_accept;
   logic       w_deliver;
   logic [2:0] w_syn;
   logic       w_par;
   logic [6:0] w_mask;
   logic [6:0] w_fix;
   logic       w_sec;
   logic       w_ded;
   logic [3:0] w_pos;
   logic [8:0] w_data;

   // Stage 2 frees up when empty or delivering; stage 1 drains into it whenever it does.
   always_comb begin
      w_s2_adv  = ~r_s2_valid | io_bus.i_ready;
      w_s1_adv  = r_s1_valid & w_s2_adv;
      w_ready   = r_rdy_en & (~r_s1_valid | w_s1_adv);
      w_accept  = io_bus.i_valid & w_ready;
      w_deliver = r_s2_valid & io_bus.i_ready;
   end

   always_comb begin
      w_syn[0] = io_bus.i_code[0] ^ io_bus.i_code[2] ^ io_bus.i_code[4] ^ io_bus.i_code[6];
      w_syn[1] = io_bus.i_code[1] ^ io_bus.i_code[2] ^ io_bus.i_code[5] ^ io_bus.i_code[6];
      w_syn[2] = io_bus.i_code[3] ^ io_bus.i_code[4] ^ io_bus.i_code[5] ^ io_bus.i_code[6];
      w_par    = ^io_bus.i_code[7:0];
   end

   always_comb begin
      w_mask = 7'b000_0001 << (r_s1_syn - 3'd1);
      w_fix  = r_s1_code[6:0];
      w_sec  = 1'b0;
      w_ded  = 1'b0;
      w_pos  = 4'd0;
      case ({r_s1_syn != 3'd0, r_s1_par})
         2'b11: begin
            w_fix = r_s1_code[6:0] ^ w_mask;
            w_sec = 1'b1;
            w_pos = {1'b0, r_s1_syn};
         end
         // Only the overall parity bit itself is wrong; the data bits are intact.
         2'b01: begin
            w_sec = 1'b1;
            w_pos = 4'd8;
         end
         2'b10: w_ded = 1'b1;
         default: ;
      endcase
      w_data = {r_s1_code[8], 4'b0000, w_fix[6], w_fix[5], w_fix[4], w_fix[2]};
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rdy_en <= 1'b0;
      end else begin
         r_rdy_en <= 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_code  <= '0;
         r_s1_syn   <= '0;
         r_s1_par   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_code  <= io_bus.i_code;
            r_s1_syn   <= w_syn;
            r_s1_par   <= w_par;
         end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s2_valid <= 1'b0;
         r_s2_data  <= '0;
         r_s2_sec   <= 1'b0;
         r_s2_ded   <= 1'b0;
         r_s2_pos   <= '0;
      end else begin
         if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
         end
         if (w_s1_adv) begin
            r_s2_data <= w_data;
            r_s2_sec  <= w_sec;
            r_s2_ded  <= w_ded;
            r_s2_pos  <= w_pos;
         end
      end
   end

   // Clear has priority over a coincident increment.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sec_cnt <= '0;
         r_ded_cnt <= '0;
      end else if (i_clr) begin
         r_sec_cnt <= '0;
         r_ded_cnt <= '0;
      end else if (w_deliver) begin
         if (r_s2_sec && (r_sec_cnt != CntMax)) begin
            r_sec_cnt <= r_sec_cnt + 1'b1;
         end
         if (r_s2_ded && (r_ded_cnt != CntMax)) begin
            r_ded_cnt <= r_ded_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      io_bus.o_ready   = w_ready;
      io_bus.o_valid   = r_s2_valid;
      io_bus.o_data    = r_s2_data;
      io_bus.o_sec     = r_s2_valid & r_s2_sec;
      io_bus.o_ded     = r_s2_valid & r_s2_ded;
      io_bus.o_err_pos = r_s2_pos;
      o_sec_cnt        = r_sec_cnt;
      o_ded_cnt        = r_ded_cnt;
   end

endmodule

// File: tb/tb_hamming74_dec.sv
// Bench for hamming74_dec: directed known-answer words plus randomized traffic scored against a
// position-sum syndrome model, with backpressure, counter saturation/clear and mid-flight reset.
module tb_hamming74_dec;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

   logic             clk   = 1'b0;
   logic             rst_n = 1'b1;
   logic             clr   = 1'b0;
   logic [CNT_W-1:0] sec_cnt;
   logic [CNT_W-1:0] ded_cnt;

   hamming74_dec_if u_if ();

   hamming74_dec #(.CNT_W(CNT_W)) u_dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .io_bus   (u_if),
      .i_clr    (clr),
      .o_sec_cnt(sec_cnt),
      .o_ded_cnt(ded_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [8:0] data;
      logic       sec;
      logic       ded;
      logic [3:0] pos;
   } exp_t;

   exp_t        q[$];
   exp_t        m_e;
   int          n_vec   = 0;
   int          n_err   = 0;
   int          n_deliv = 0;
   int          m_sec   = 0;
   int          m_ded   = 0;
   logic [15:0] cur_out;
   logic [15:0] prev_out   = '0;
   logic        prev_stall = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Syndrome = XOR of the 1-based positions of all set code bits.
   function automatic exp_t model(input logic [8:0] c);
      exp_t       e;
      int         syn;
      int         par;
      logic [6:0] w;
      e   = '0;
      syn = 0;
      w   = c[6:0];
      for (int i = 0; i < 7; i++) if (c[i]) syn = syn ^ (i + 1);
      par = $countones(c[7:0]) % 2;
      if (syn != 0 && par == 1) begin
         w     = w ^ 7'(1 << (syn - 1));
         e.sec = 1'b1;
         e.pos = 4'(syn);
      end else if (syn == 0 && par == 1) begin
         e.sec = 1'b1;
         e.pos = 4'd8;
      end else if (syn != 0) begin
         e.ded = 1'b1;
      end
      e.data = {c[8], 4'b0000, w[6], w[5], w[4], w[2]};
      return e;
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            q.delete();
            m_sec      = 0;
            m_ded      = 0;
            prev_stall = 1'b0;
         end else begin
            cur_out = {u_if.o_valid, u_if.o_data, u_if.o_sec, u_if.o_ded, u_if.o_err_pos};
            check_eq("sec_cnt", 32'(sec_cnt), 32'(m_sec));
            check_eq("ded_cnt", 32'(ded_cnt), 32'(m_ded));
            check_eq("sec_ded_excl", 32'(u_if.o_sec & u_if.o_ded), 32'd0);
            if (!u_if.o_valid) check_eq("idle_flags", 32'({u_if.o_sec, u_if.o_ded}), 32'd0);
            if (prev_stall) check_eq("stall_hold", 32'(cur_out), 32'(prev_out));
            if (u_if.o_valid && u_if.i_ready) begin
               n_deliv++;
               check_eq("q_nonempty", 32'(q.size() != 0), 32'd1);
               if (q.size() != 0) begin
                  m_e = q.pop_front();
                  check_eq("data", 32'(u_if.o_data), 32'(m_e.data));
                  check_eq("sec", 32'(u_if.o_sec), 32'(m_e.sec));
                  check_eq("ded", 32'(u_if.o_ded), 32'(m_e.ded));
                  check_eq("err_pos", 32'(u_if.o_err_pos), 32'(m_e.pos));
                  if (m_e.sec && m_sec < CNT_MAX) m_sec++;
                  if (m_e.ded && m_ded < CNT_MAX) m_ded++;
               end
            end
            if (clr) begin
               m_sec = 0;
               m_ded = 0;
            end
            if (u_if.i_valid && u_if.o_ready) q.push_back(model(u_if.i_code));
            prev_stall = u_if.o_valid & ~u_if.i_ready;
            prev_out   = cur_out;
         end
      end
   end

   // Called at posedge+1 with an empty pipeline and i_ready high; returns after delivery.
   task automatic directed(input string tag, input logic [8:0] code, input logic [8:0] e_data,
                           input logic e_sec, input logic e_ded, input logic [3:0] e_pos);
      u_if.i_code  = code;
      u_if.i_valid = 1'b1;
      @(posedge clk);
      #1 u_if.i_valid = 1'b0;
      check_eq({tag, "_early"}, 32'(u_if.o_valid), 32'd0);
      @(posedge clk);
      #1;
      check_eq({tag, "_valid"}, 32'(u_if.o_valid), 32'd1);
      check_eq({tag, "_data"}, 32'(u_if.o_data), 32'(e_data));
      check_eq({tag, "_sec"}, 32'(u_if.o_sec), 32'(e_sec));
      check_eq({tag, "_ded"}, 32'(u_if.o_ded), 32'(e_ded));
      check_eq({tag, "_pos"}, 32'(u_if.o_err_pos), 32'(e_pos));
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [8:0] code);
      int   n;
      logic acc;
      n            = 0;
      acc          = 1'b0;
      u_if.i_code  = code;
      u_if.i_valid = 1'b1;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = u_if.o_ready;
         @(posedge clk);
         #1;
         n++;
      end
      u_if.i_valid = 1'b0;
      if (!acc) check_eq("push_timeout", 32'(acc), 32'd1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q.size() != 0 || u_if.o_valid) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_eq("drain", 32'(q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, n_err=%0d", n_err);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int d0;
      u_if.i_code  = '0;
      u_if.i_valid = 1'b0;
      u_if.i_ready = 1'b1;
      #1 rst_n = 1'b0;
      #3;
      check_eq("rst_valid", 32'(u_if.o_valid), 32'd0);
      check_eq("rst_ready", 32'(u_if.o_ready), 32'd0);
      check_eq("rst_data", 32'(u_if.o_data), 32'd0);
      check_eq("rst_flags", 32'({u_if.o_sec, u_if.o_ded}), 32'd0);
      check_eq("rst_pos", 32'(u_if.o_err_pos), 32'd0);
      check_eq("rst_cnts", 32'({sec_cnt, ded_cnt}), 32'd0);
      repeat (2) @(posedge clk);
      #1 check_eq("rst_ready_hold", 32'(u_if.o_ready), 32'd0);
      rst_n = 1'b1;
      #1 check_eq("rel_ready", 32'(u_if.o_ready), 32'd0);
      @(posedge clk);
      #1 check_eq("rel_ready_edge", 32'(u_if.o_ready), 32'd1);

      directed("clean", 9'h055, 9'h00B, 1'b0, 1'b0, 4'd0);
      directed("sec_d", 9'h045, 9'h00B, 1'b1, 1'b0, 4'd5);
      check_eq("sec_cnt_1", 32'(sec_cnt), 32'd1);
      directed("sec_p", 9'h0D5, 9'h00B, 1'b1, 1'b0, 4'd8);
      check_eq("sec_cnt_2", 32'(sec_cnt), 32'd2);
      directed("ded", 9'h156, 9'h10B, 1'b0, 1'b1, 4'd0);
      check_eq("ded_cnt_1", 32'(ded_cnt), 32'd1);

      // Eight-word burst with a three-cycle downstream stall in the middle.
      d0 = n_deliv;
      fork
         for (int i = 0; i < 8; i++) push_word(9'($urandom));
         begin
            repeat (3) @(posedge clk);
            #1 u_if.i_ready = 1'b0;
            @(negedge clk);
            check_eq("bp_ready_low", 32'(u_if.o_ready), 32'd0);
            check_eq("bp_out_valid", 32'(u_if.o_valid), 32'd1);
            repeat (3) @(posedge clk);
            #1 u_if.i_ready = 1'b1;
         end
      join
      drain();
      check_eq("bp_count", 32'(n_deliv - d0), 32'd8);

      for (int i = 0; i < 400; i++) begin
         u_if.i_valid = 1'($urandom_range(0, 1));
         u_if.i_code  = 9'($urandom);
         u_if.i_ready = ($urandom_range(0, 3) != 0);
         clr          = ($urandom_range(0, 31) == 0);
         @(posedge clk);
         #1;
      end
      u_if.i_valid = 1'b0;
      u_if.i_ready = 1'b1;
      clr          = 1'b0;
      drain();

      clr = 1'b1;
      @(posedge clk);
      #1 clr = 1'b0;
      for (int i = 0; i < 20; i++) push_word(9'h045);
      drain();
      check_eq("sat_sec", 32'(sec_cnt), 32'(CNT_MAX));

      clr = 1'b1;
      @(posedge clk);
      #1 clr = 1'b0;
      push_word(9'h045);
      drain();
      check_eq("pre_clr", 32'(sec_cnt), 32'd1);
      u_if.i_ready = 1'b0;
      push_word(9'h045);
      @(posedge clk);
      #1 check_eq("clr_stage", 32'(u_if.o_valid), 32'd1);
      u_if.i_ready = 1'b1;
      clr          = 1'b1;
      @(posedge clk);
      #1 clr = 1'b0;
      check_eq("clr_wins", 32'(sec_cnt), 32'd0);

      // Two words in flight when reset hits: neither may come out afterwards.
      u_if.i_ready = 1'b0;
      push_word(9'h055);
      push_word(9'h156);
      d0    = n_deliv;
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_valid", 32'(u_if.o_valid), 32'd0);
      check_eq("mid_rst_ready", 32'(u_if.o_ready), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b0;
      rst_n        = 1'b1;
      u_if.i_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check_eq("rst_flush", 32'(n_deliv - d0), 32'd0);
      check_eq("rst_flush_valid", 32'(u_if.o_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
